alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU instance between two requesters, called requester 0 and requester 1. The block arbitrates between them, registers the operands, and drives the ALU inputs for one execute cycle. It captures the result, including the set-less-than flag, and returns it to the granted requester over a valid/ready response channel. It sits between the instruction-issue logic and the ALU in the processor datapath.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU instance.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a, req0_b  in  DATA_WIDTH each  requester 0 operands (signed)
req0_op  in  3  requester 0 ALU opcode
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes the result
req1_*, rsp1_*  (same set as requester 0)  requester 1 channel
rsp_data  out  DATA_WIDTH  result, shared by both response channels
rsp_err  out  1  illegal opcode flag, shared by both response channels
alu_a, alu_b  out  DATA_WIDTH each  ALU operand drive
alu_opcode  out  3  ALU opcode drive
alu_out  in  DATA_WIDTH  ALU result
alu_less  in  1  ALU less flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n sampled low at a rising edge):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All req*_ready=0 and rsp*_valid=0.
  - rsp_data=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_opcode=3'b000.
- Reset mid-operation: aborts the operation and discards any pending result. No response is issued.
- Legal opcodes:
  - 010 add
  - 110 sub
  - 000 and
  - 001 or
  - 111 slt
  - Any other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req*_valid is high, grant one requester:
    - Both valid: grant the requester that is not last_grant (round-robin).
    - One valid: grant that requester.
  - reqN_ready is asserted combinationally in the same cycle for the granted requester only. The ungranted requester's ready stays 0.
  - At the edge: latch a, b and op into internal registers and record the grant.
  - Next state: EXEC if the opcode is legal, otherwise RESP with err=1 and data=0.
- EXEC:
  - alu_a, alu_b and alu_opcode are driven from the latched registers. They hold those values until the next grant.
  - At the end of the cycle, capture rsp_data:
    - Opcodes 111: {DATA_WIDTH-1 zeros, alu_less}.
    - All other legal opcodes: alu_out, truncated to DATA_WIDTH (wrap-around, no saturation).
  - Capture rsp_err=0. Go to RESP.
- RESP:
  - rspN_valid=1 for the granted requester only.
  - rsp_data and rsp_err stay stable until the handshake.
  - On rspN_valid && rspN_ready: set last_grant to the granted requester and go to IDLE.
  - New requests are not accepted while in EXEC or RESP; all req*_ready=0.
- Latency and throughput:
  - Request accepted at edge T gives rsp_valid high in cycle T+2.
  - Illegal opcode gives rsp_valid high in cycle T+1.
  - With rsp_ready held high, peak throughput is one operation per 3 cycles.
- Back-pressure: an arbitrarily long rsp_ready=0 stalls in RESP, and the other requester waits. No starvation in round-robin mode: a waiting requester is granted next.
- Opcode values: req*_op is only sampled when that requester is granted, so X on an idle channel is harmless.

Optional Feature:
ALU_ARB_FIXED_PRIORITY_EN
- Defined: requester 0 always wins when both are valid. last_grant is still maintained but ignored, and requester 1 may starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset, then req0 add with a=5, b=3 → req0_ready pulses 1 cycle, alu_opcode=010 in EXEC, rsp0_valid at T+2 with rsp_data=8, rsp_err=0, rsp1_valid=0.
- req1 slt with a=-2, b=1, then a=3, b=-4 → rsp_data=1, then rsp_data=0. Also sub with a=-128, b=1 → rsp_data=127 (wrap).
- Both valid every cycle, rsp ready high, 4 operations → grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIORITY_EN → grants 0,0,0,0.
- req0 op=3'b011 → rsp0_valid at T+1, rsp_err=1, rsp_data=0, ALU inputs unchanged from the previous operation.
- rsp0_ready held low 10 cycles with req1 valid → rsp_data stable, req1_ready=0 throughout. req1 granted in the IDLE cycle right after the handshake.
- rst_n low during EXEC, then during RESP → next cycle all outputs at reset values, no rsp_valid. The next request after reset completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrate, issue, return result.
// Define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 always win ties (default: round-robin).
module alu_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [2:0]            req0_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [2:0]            req1_op,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_less
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]            alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  pick;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic [2:0]            sel_op;
    logic                  sel_legal;
    logic                  rsp_hs;

    always_comb begin
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            pick = 1'b0;
`else
            pick = ~last_grant_q;
`endif
        end else begin
            pick = ~req0_valid;
        end
        sel_a     = pick ? req1_a  : req0_a;
        sel_b     = pick ? req1_b  : req0_b;
        sel_op    = pick ? req1_op : req0_op;
        sel_legal = (sel_op == OP_ADD) || (sel_op == OP_SUB) || (sel_op == OP_AND) ||
                    (sel_op == OP_OR)  || (sel_op == OP_SLT);
        rsp_hs    = grant_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    grant_d    = pick;
                    if (sel_legal) begin
                        // ALU drive only moves on legal grants so an illegal op leaves it untouched
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                        state_d  = EXEC;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_data_d = (alu_op_q == OP_SLT) ? {{(DATA_WIDTH-1){1'b0}}, alu_less} : alu_out;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'b000;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) &&  grant_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle plus literal checks.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [7:0] rsp_data, alu_a, alu_b, alu_out;
    logic       rsp_err, alu_less;
    logic [2:0] alu_opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_less(alu_less)
    );

    // Behavioural ALU
    always_comb begin
        case (alu_opcode)
            3'b010:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a - alu_b;
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            default: alu_out = 8'h00;
        endcase
        alu_less = $signed(alu_a) < $signed(alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [2:0] op);
        return op == 3'b010 || op == 3'b110 || op == 3'b000 || op == 3'b001 || op == 3'b111;
    endfunction

    function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'b010:  r = sa + sb;
            3'b110:  r = sa - sb;
            3'b000:  r = sa & sb;
            3'b001:  r = sa | sb;
            3'b111:  r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Transaction model: one op in flight, visible after 1 (illegal) or 2 (legal) cycles
    logic       started = 1'b0;
    logic       m_busy, m_gnt, m_lg, m_err;
    int         m_cnt;
    logic [7:0] m_res, m_alu_a, m_alu_b;
    logic [2:0] m_alu_op;
    logic       m_win;
    logic [7:0] w_a, w_b;
    logic [2:0] w_op;

    always_comb begin
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            m_win = 1'b0;
`else
            m_win = (m_lg == 1'b0);
`endif
        end else begin
            m_win = !req0_valid;
        end
        w_a  = m_win ? req1_a  : req0_a;
        w_b  = m_win ? req1_b  : req0_b;
        w_op = m_win ? req1_op : req0_op;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            started  <= 1'b1;
            m_busy   <= 1'b0;
            m_lg     <= 1'b1;
            m_gnt    <= 1'b0;
            m_cnt    <= 0;
            m_err    <= 1'b0;
            m_res    <= 8'h00;
            m_alu_a  <= 8'h00;
            m_alu_b  <= 8'h00;
            m_alu_op <= 3'b000;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1'b1;
                m_gnt  <= m_win;
                m_cnt  <= 1;
                m_err  <= !legal(w_op);
                m_res  <= ref_res(w_a, w_b, w_op);
                if (legal(w_op)) begin
                    m_alu_a  <= w_a;
                    m_alu_b  <= w_b;
                    m_alu_op <= w_op;
                end
            end
        end else if (m_cnt >= (m_err ? 1 : 2) && (m_gnt ? rsp1_ready : rsp0_ready)) begin
            m_busy <= 1'b0;
            m_lg   <= m_gnt;
        end else if (m_cnt < 8) begin
            m_cnt <= m_cnt + 1;
        end
    end

    int         gnt_log[$];
    logic [7:0] last0, last1;
    logic       rsp_vis;

    always @(negedge clk) begin
        if (started) begin
            rsp_vis = m_busy && (m_cnt >= (m_err ? 1 : 2));
            chk("req0_ready", req0_ready, rst_n && !m_busy && (req0_valid || req1_valid) && !m_win);
            chk("req1_ready", req1_ready, rst_n && !m_busy && (req0_valid || req1_valid) &&  m_win);
            chk("rsp0_valid", rsp0_valid, rsp_vis && !m_gnt);
            chk("rsp1_valid", rsp1_valid, rsp_vis &&  m_gnt);
            chk("alu_a", alu_a, m_alu_a);
            chk("alu_b", alu_b, m_alu_b);
            chk("alu_opcode", alu_opcode, m_alu_op);
            if (rsp_vis) begin
                chk("rsp_data", rsp_data, m_res);
                chk("rsp_err", rsp_err, m_err);
            end
            if (req0_ready) gnt_log.push_back(0);
            if (req1_ready) gnt_log.push_back(1);
            if (rsp0_valid && rsp0_ready) last0 = rsp_data;
            if (rsp1_valid && rsp1_ready) last1 = rsp_data;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (caller guarantees the block is idle)
    task automatic send(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (ch == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else         begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        step(1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        step(2);
        @(negedge clk);
        chk("reset rsp_data", rsp_data, 8'h00);
        chk("reset rsp_err", rsp_err, 1'b0);
        chk("reset rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("reset alu", {alu_a, alu_b, alu_opcode}, 19'h0);
        rst_n = 1;
        step(1);

        // add 5+3 on requester 0
        req0_valid = 1; req0_a = 8'd5; req0_b = 8'd3; req0_op = 3'b010;
        @(negedge clk);
        chk("add ready pulse", {req0_ready, req1_ready}, 2'b10);
        step(1);
        req0_valid = 0;
        @(negedge clk);
        chk("add ready drop", req0_ready, 1'b0);
        chk("add exec opcode", alu_opcode, 3'b010);
        chk("add exec rsp0_valid", rsp0_valid, 1'b0);
        step(1);
        @(negedge clk);
        chk("add T+2 valid", {rsp0_valid, rsp1_valid}, 2'b10);
        chk("add data", rsp_data, 8'd8);
        chk("add err", rsp_err, 1'b0);
        step(2);

        // slt and wrap-around sub on requester 1
        send(1, 8'hFE, 8'h01, 3'b111); step(3);
        chk("slt -2<1", last1, 8'd1);
        send(1, 8'h03, 8'hFC, 3'b111); step(3);
        chk("slt 3<-4", last1, 8'd0);
        send(1, 8'h80, 8'h01, 3'b110); step(3);
        chk("sub wrap", last1, 8'd127);

        // both requesters valid for four grants
        gnt_log.delete();
        req0_valid = 1; req0_a = 8'd10; req0_b = 8'd20; req0_op = 3'b010;
        req1_valid = 1; req1_a = 8'd30; req1_b = 8'd40; req1_op = 3'b001;
        step(10);
        req0_valid = 0; req1_valid = 0;
        step(5);
        chk("grant count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            chk("grant order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0000);
`else
            chk("grant order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0101);
`endif
        end

        // illegal opcode: response next cycle, ALU drive untouched
        send(1, 8'd11, 8'd22, 3'b010); step(3);
        send(0, 8'd99, 8'd77, 3'b011);
        @(negedge clk);
        chk("illegal T+1 valid", rsp0_valid, 1'b1);
        chk("illegal err", rsp_err, 1'b1);
        chk("illegal data", rsp_data, 8'h00);
        chk("illegal alu held", {alu_a, alu_b, alu_opcode}, {8'd11, 8'd22, 3'b010});
        step(2);

        // back-pressure on requester 0 while requester 1 waits
        rsp0_ready = 0;
        send(0, 8'd9, 8'd4, 3'b001);
        req1_valid = 1; req1_a = 8'd7; req1_b = 8'd2; req1_op = 3'b001;
        step(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall valid", rsp0_valid, 1'b1);
            chk("stall data", rsp_data, 8'd13);
            chk("stall req1_ready", req1_ready, 1'b0);
            step(1);
        end
        rsp0_ready = 1;
        step(1);
        @(negedge clk);
        chk("req1 granted after hs", req1_ready, 1'b1);
        step(1);
        req1_valid = 0;
        step(3);
        chk("stalled result", last0, 8'd13);
        chk("waiting result", last1, 8'd7);

        // reset during EXEC
        send(0, 8'd1, 8'd2, 3'b010);
        rst_n = 0;
        step(1);
        @(negedge clk);
        chk("rst exec valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst exec outs", {alu_a, alu_b, alu_opcode, rsp_data, rsp_err}, 28'h0);
        rst_n = 1;
        step(1);

        // reset during RESP
        rsp0_ready = 0;
        send(0, 8'd4, 8'd4, 3'b010);
        step(1);
        rst_n = 0;
        step(1);
        @(negedge clk);
        chk("rst resp valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst resp outs", {alu_a, alu_b, alu_opcode, rsp_data, rsp_err}, 28'h0);
        rst_n = 1;
        rsp0_ready = 1;
        step(2);
        send(1, 8'd1, 8'd1, 3'b010); step(3);
        chk("post reset op", last1, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
